// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the FSM state codes, the supported opcode/funct values, the 3-bit
// ALU operation codes and the ALU-B / PC-source mux encodings, plus a
// helper that tells whether an R-type funct is one the datapath executes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // True for the five R-type functs the ALU can execute.
    function automatic logic is_rtype_funct(input logic [5:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
               (f == FUNCT_OR)  || (f == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU operation decoder for the multi-cycle controller.
// Ports:
//   state        in  current controller state
//   funct        in  instruction[5:0]
//   aluop_to_alu out 3-bit ALU operation for this cycle
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  funct,
    output logic [2:0]  aluop_to_alu
);

    // Address/PC/immediate states add, BRANCH compares by subtracting,
    // REXEC follows funct; states that do not use the ALU drive 000.
    always_comb begin
        aluop_to_alu = 3'b000;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR, S_IEXEC: aluop_to_alu = ALU_ADD;
            S_BRANCH:                             aluop_to_alu = ALU_SUB;
            S_REXEC: begin
                case (funct)
                    FUNCT_SUB: aluop_to_alu = ALU_SUB;
                    FUNCT_AND: aluop_to_alu = ALU_AND;
                    FUNCT_OR:  aluop_to_alu = ALU_OR;
                    FUNCT_SLT: aluop_to_alu = ALU_SLT;
                    default:   aluop_to_alu = ALU_ADD;
                endcase
            end
            default: aluop_to_alu = 3'b000;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore-style control FSM for a multi-cycle MIPS datapath with a shared
// instruction/data memory and a single reused ALU.
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   op, funct, zero            instruction fields from the IR, ALU zero flag
//   mem_ready                  memory finished the current access this cycle
//   iord..pcen                 datapath mux selects and write strobes
//   aluop_to_alu               3-bit ALU operation
//   instr_done                 pulse on the last cycle of a retired instruction
//   illegal                    pulse in DECODE for an unsupported instruction
//   state                      current state code (debug)
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  aluop_to_alu,
    output logic [1:0]  pcsrc,
    output logic        pcen,
    output logic        instr_done,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] aluop_raw;

    mips_alu_decoder u_alu_decoder (
        .state        (state_q),
        .funct        (funct),
        .aluop_to_alu (aluop_raw)
    );

    // Reset forces the ALU op to zero together with every other control.
    assign aluop_to_alu = reset ? 3'b000 : aluop_raw;
    assign state        = state_q;

    // Next state and per-state controls. irwrite/pcen in FETCH, the MEMWR
    // completion and the branch decision depend on live inputs, so they are
    // decoded here from the current state rather than registered.
    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PC_ALU;
        pcen       = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_IMM_SHL2;
                case (op)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_ADDI:         state_d = S_IEXEC;
                    OP_J:            state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (is_rtype_funct(funct)) begin
                            state_d = S_REXEC;
                        end else begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    default: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_REXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_B;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_B;
                pcsrc      = PC_ALUOUT;
                pcen       = (op == OP_BEQ) ? zero : ~zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_IWB;
            end
            S_IWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc      = PC_JUMP;
                pcen       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // While reset is held nothing may be written or requested.
        if (reset) begin
            iord       = 1'b0;
            memread    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = SRCB_B;
            pcsrc      = PC_ALU;
            pcen       = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) state_q <= state_t'(RESET_STATE);
        else       state_q <= state_d;
    end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Moore-style control FSM that sequences a multi-cycle MIPS datapath: shared instruction/data memory, instruction register, and one ALU reused for PC+4, branch target and execute.
- Replaces the single-cycle combinational control unit.
- Drives the mux selects, write strobes and the 3-bit ALU operation every cycle.
- Stalls on a memory ready handshake, so memory latency may vary.

Parameters:
- RESET_STATE, 4'd0, state code loaded on reset (FETCH).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; forces FETCH on the next rising edge.
- op  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  load the instruction register.
- regdst  out  1  register write address: 1 = rd, 0 = rt.
- memtoreg  out  1  register write data: 1 = MDR, 0 = ALUOut.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A input: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop_to_alu  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump address.
- pcen  out  1  PC write enable.
- instr_done  out  1  one-cycle pulse on the last cycle of each retired instruction.
- illegal  out  1  one-cycle pulse in DECODE when the opcode or funct is unsupported.
- state  out  4  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, go to FETCH with all strobes 0.
- Reset: while reset=1, every strobe output is 0 and state updates to FETCH at the clock edge. The first FETCH cycle is the cycle after reset deasserts. Reset asserted mid-instruction aborts it with no write.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite and pcen are asserted only in the cycle where mem_ready=1; that cycle also moves to DECODE.
  - mem_ready=0 keeps the FSM in FETCH.
- DECODE: alusrca=0, alusrcb=11, add (computes the branch target into ALUOut). Next state by op:
  - 100011 lw -> MEMADR.
  - 101011 sw -> MEMADR.
  - 000000 R-type: funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt -> REXEC.
  - 000100 beq -> BRANCH.
  - 000101 bne -> BRANCH.
  - 001000 addi -> IEXEC.
  - 000010 j -> JUMP.
  - Anything else: illegal=1, instr_done=1, next state FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, instr_done=1. Next state FETCH.
- MEMWR: memwrite=1, iord=1, held stable until mem_ready=1. On that cycle instr_done=1 and next state is FETCH.
- REXEC: alusrca=1, alusrcb=00, ALU op from funct (the 5 functs map to add/sub/and/or/slt codes). Next state ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for beq, !zero for bne.
  - instr_done=1. Next state FETCH.
- IEXEC: alusrca=1, alusrcb=10, add. Next state IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1. Next state FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1. Next state FETCH.
- Op/funct are sampled combinationally in DECODE and later states; the instruction register is stable because irwrite is asserted only in FETCH.
- Latency with mem_ready tied 1: lw 5 cycles, sw/R/addi 4, beq/bne/j 3.
- Every strobe not listed for a state is 0 in that state. memread and memwrite are never both 1.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state codes;
  - the opcode and funct constants;
  - the ALU op codes;
  - the alusrcb and pcsrc encodings.
- One sub-module, mips_alu_decoder: combinational mapping of (state, funct) to aluop_to_alu.

Test Plan:
- Reset held 3 cycles mid-REXEC, then released -> all strobes 0 during reset; state=0 the cycle after release; no regwrite issued.
- lw (op 100011), mem_ready=1 -> state sequence 0,1,2,3,4; regwrite=1 with memtoreg=1 only in state 4; instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles; instr_done on the 4th; then FETCH.
- beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH. bne with zero=1 -> pcen=0. Both take 3 cycles.
- R-type slt (funct 101010) -> aluop_to_alu=111 in REXEC; regdst=1 and regwrite=1 in ALUWB.
- op 111111, and separately R-type funct 000111 -> illegal pulses in DECODE; next state FETCH; no regwrite, memwrite or pcen in that instruction.
